eth_tx_arb: RTL and testbench

ETH_TX_ARB -- requirements
Module: eth_tx_arb

---
 rtl/eth_tx_arb.sv | 148 ++++++++++++++
 tb/tb_eth_tx_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb.sv
// Two-source round-robin frame arbiter feeding one MAC byte stream; grant is issued one cycle after a sof request.
// The MAC's tx_ack paces the granted source directly; orphan bytes arriving while idle are acked and discarded.
module eth_tx_arb #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_mac,
  input  logic             rst,
  input  logic [1:0]       port_en,
  input  logic [1:0]       src_vld,
  input  logic [15:0]      src_dat,
  input  logic [1:0]       src_sof,
  input  logic [1:0]       src_eof,
  output logic [1:0]       src_ack,
  output logic             tx_vld,
  output logic [7:0]       tx_dat,
  output logic             tx_sof,
  output logic             tx_eof,
  input  logic             tx_ack,
  output logic [CNT_W-1:0] frm_cnt0,
  output logic [CNT_W-1:0] frm_cnt1,
  output logic [7:0]       drop_cnt,
  output logic             underrun
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_grant;
  logic             w_grant_nxt;
  logic             r_last_grant;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_frm_cnt0;
  logic [CNT_W-1:0] r_frm_cnt1;
  logic [7:0]       r_drop_cnt;
  logic             r_underrun;
  logic             w_underrun_nxt;
  logic             w_frm_done;

  logic [1:0]       w_req;
  logic [1:0]       w_orphan;
  logic             w_winner;
  logic [1:0]       w_drop_inc;
  logic [8:0]       w_drop_sum;
  logic [7:0]       w_drop_nxt;

  logic             w_sel_vld;
  logic [7:0]       w_sel_dat;
  logic             w_sel_sof;
  logic             w_sel_eof;

  assign w_req    = port_en & src_vld & src_sof;
  assign w_orphan = port_en & src_vld & ~src_sof;

  // With both requesting, the port that did not go last wins.
  assign w_winner = (&w_req) ? ~r_last_grant : w_req[1];

  assign w_sel_vld = r_grant ? src_vld[1]     : src_vld[0];
  assign w_sel_dat = r_grant ? src_dat[15:8]  : src_dat[7:0];
  assign w_sel_sof = r_grant ? src_sof[1]     : src_sof[0];
  assign w_sel_eof = r_grant ? src_eof[1]     : src_eof[0];

  assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};
  assign w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last_grant;
    w_underrun_nxt = 1'b0;
    w_frm_done     = 1'b0;
    w_drop_inc     = 2'd0;
    src_ack        = 2'b00;
    tx_vld         = 1'b0;
    tx_dat         = 8'h00;
    tx_sof         = 1'b0;
    tx_eof         = 1'b0;
    // Gating on rst drops the stream in the same cycle reset rises, ahead of the flops.
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          src_ack    = w_orphan;
          w_drop_inc = {1'b0, w_orphan[0]} + {1'b0, w_orphan[1]};
          if (|w_req) begin
            w_state_nxt = S_BUSY;
            w_grant_nxt = w_winner;
          end
        end
        S_BUSY: begin
          tx_vld           = w_sel_vld;
          tx_dat           = w_sel_dat;
          tx_sof           = w_sel_sof;
          tx_eof           = w_sel_eof;
          src_ack[r_grant] = tx_ack;
          if (tx_ack) begin
            if (!w_sel_vld) begin
              // MAC closed the frame on a starved source: truncated, not counted.
              w_state_nxt    = S_IDLE;
              w_last_nxt     = r_grant;
              w_underrun_nxt = 1'b1;
            end else if (w_sel_eof) begin
              w_state_nxt = S_IDLE;
              w_last_nxt  = r_grant;
              w_frm_done  = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_frm_cnt0   <= '0;
      r_frm_cnt1   <= '0;
      r_drop_cnt   <= 8'd0;
      r_underrun   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_drop_cnt   <= w_drop_nxt;
      r_underrun   <= w_underrun_nxt;
      if (w_frm_done) begin
        if (r_grant) begin
          r_frm_cnt1 <= r_frm_cnt1 + CNT_ONE;
        end else begin
          r_frm_cnt0 <= r_frm_cnt0 + CNT_ONE;
        end
      end
    end
  end

  assign frm_cnt0 = r_frm_cnt0;
  assign frm_cnt1 = r_frm_cnt1;
  assign drop_cnt = r_drop_cnt;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: arbitration table plus frame-level scoreboard sequences.
module tb_eth_tx_arb;
  localparam int CNT_W = 16;

  logic             clk_mac = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       port_en = 2'b00;
  logic [1:0]       src_vld = 2'b00;
  logic [15:0]      src_dat = 16'h0000;
  logic [1:0]       src_sof = 2'b00;
  logic [1:0]       src_eof = 2'b00;
  logic [1:0]       src_ack;
  logic             tx_vld;
  logic [7:0]       tx_dat;
  logic             tx_sof;
  logic             tx_eof;
  logic             tx_ack = 1'b0;
  logic [CNT_W-1:0] frm_cnt0;
  logic [CNT_W-1:0] frm_cnt1;
  logic [7:0]       drop_cnt;
  logic             underrun;

  eth_tx_arb #(.CNT_W(CNT_W)) dut (
    .clk_mac (clk_mac),
    .rst     (rst),
    .port_en (port_en),
    .src_vld (src_vld),
    .src_dat (src_dat),
    .src_sof (src_sof),
    .src_eof (src_eof),
    .src_ack (src_ack),
    .tx_vld  (tx_vld),
    .tx_dat  (tx_dat),
    .tx_sof  (tx_sof),
    .tx_eof  (tx_eof),
    .tx_ack  (tx_ack),
    .frm_cnt0(frm_cnt0),
    .frm_cnt1(frm_cnt1),
    .drop_cnt(drop_cnt),
    .underrun(underrun)
  );

  always #10 clk_mac = ~clk_mac;

  typedef struct packed {
    logic [7:0] dat;
    logic       sof;
    logic       eof;
  } exp_t;

  typedef struct {
    logic [1:0] en;
    logic [1:0] vld;
    logic [1:0] sof;
    logic [1:0] exp_ack;
    logic       exp_gv;
    logic       exp_g;
    logic [7:0] exp_drop;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[12];

  int n_chk = 0;
  int n_fail = 0;
  int n_under = 0;
  int cyc = 0;
  int ack_div = 1;
  logic ack1_seen = 1'b0;
  logic model_on = 1'b0;
  int nfrm[2];
  int flen[2];
  int fidx[2];
  int fcnt[2];
  int cut[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int p, input int f, input int i);
    return {p[0], f[0], i[5:0]};
  endfunction

  task automatic drive_src();
    for (int p = 0; p < 2; p++) begin
      if (model_on && nfrm[p] > 0 && fidx[p] != cut[p]) begin
        src_vld[p]         = 1'b1;
        src_sof[p]         = (fidx[p] == 0);
        src_eof[p]         = (fidx[p] == flen[p] - 1);
        src_dat[p*8 +: 8]  = byte_of(p, fcnt[p], fidx[p]);
      end else begin
        src_vld[p]         = 1'b0;
        src_sof[p]         = 1'b0;
        src_eof[p]         = 1'b0;
        src_dat[p*8 +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic set_src(input int p, input int frames, input int len, input int cutpt);
    nfrm[p] = frames;
    flen[p] = len;
    fidx[p] = 0;
    fcnt[p] = 0;
    cut[p]  = cutpt;
  endtask

  task automatic expect_frame(input int p, input int f, input int n, input int len);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.dat = byte_of(p, f, i);
      e.sof = (i == 0);
      e.eof = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: observe at negedge, then advance sources and MAC strobe just after posedge.
  task automatic cycle();
    logic [1:0] adv;
    exp_t e;
    @(negedge clk_mac);
    if (tx_vld && tx_ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got byte 0x%0h, expected none", tx_dat);
      end else begin
        e = exp_q.pop_front();
        chk("sb_dat", {24'd0, tx_dat}, {24'd0, e.dat});
        chk("sb_sof", {31'd0, tx_sof}, {31'd0, e.sof});
        chk("sb_eof", {31'd0, tx_eof}, {31'd0, e.eof});
      end
    end
    if (underrun) n_under++;
    if (src_ack[1]) ack1_seen = 1'b1;
    adv = model_on ? (src_ack & src_vld) : 2'b00;
    @(posedge clk_mac);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (adv[p]) begin
        fidx[p]++;
        if (fidx[p] == flen[p]) begin
          fidx[p] = 0;
          fcnt[p]++;
          nfrm[p]--;
        end
      end
    end
    cyc++;
    tx_ack = ((cyc % ack_div) == 0);
    if (model_on) drive_src();
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    cycle();
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk_mac);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          en     vld    sof    ack    gv    g     drop
    vt[0]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0};
    vt[1]  = '{2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 8'd0};
    vt[2]  = '{2'b11, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 8'd0};
    vt[3]  = '{2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 8'd0};
    vt[4]  = '{2'b01, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 8'd0};
    vt[5]  = '{2'b10, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, 8'd0};
    vt[6]  = '{2'b11, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 8'd1};
    vt[7]  = '{2'b11, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0, 8'd2};
    vt[8]  = '{2'b01, 2'b11, 2'b00, 2'b01, 1'b0, 1'b0, 8'd1};
    vt[9]  = '{2'b11, 2'b11, 2'b01, 2'b10, 1'b1, 1'b0, 8'd1};
    vt[10] = '{2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 8'd0};
    vt[11] = '{2'b11, 2'b11, 2'b10, 2'b01, 1'b1, 1'b1, 8'd1};
    for (int p = 0; p < 2; p++) set_src(p, 0, 1, -1);

    // Reset state, with orphan-looking inputs that must not be acked under reset.
    rst = 1'b1;
    port_en = 2'b11;
    src_vld = 2'b11;
    src_sof = 2'b00;
    tx_ack  = 1'b1;
    repeat (2) @(posedge clk_mac);
    #1;
    chk("rst_src_ack", {30'd0, src_ack}, 32'd0);
    chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("rst_tx_dat", {24'd0, tx_dat}, 32'd0);
    chk("rst_frm_cnt0", {16'd0, frm_cnt0}, 32'd0);
    chk("rst_frm_cnt1", {16'd0, frm_cnt1}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);

    // Arbitration / orphan table, each vector from a fresh reset.
    for (int k = 0; k < 12; k++) begin
      model_on = 1'b0;
      port_en  = vt[k].en;
      src_vld  = vt[k].vld;
      src_sof  = vt[k].sof;
      src_eof  = 2'b00;
      src_dat  = 16'hB1A0;
      tx_ack   = 1'b0;
      do_reset();
      @(negedge clk_mac);
      chk($sformatf("v%0d_idle_ack", k), {30'd0, src_ack}, {30'd0, vt[k].exp_ack});
      chk($sformatf("v%0d_idle_vld", k), {31'd0, tx_vld}, 32'd0);
      @(negedge clk_mac);
      chk($sformatf("v%0d_grant_vld", k), {31'd0, tx_vld}, {31'd0, vt[k].exp_gv});
      if (vt[k].exp_gv) begin
        chk($sformatf("v%0d_grant_dat", k), {24'd0, tx_dat}, vt[k].exp_g ? 32'hB1 : 32'hA0);
        chk($sformatf("v%0d_grant_sof", k), {31'd0, tx_sof}, 32'd1);
      end
      chk($sformatf("v%0d_drop", k), {24'd0, drop_cnt}, {24'd0, vt[k].exp_drop});
    end

    // Single 60-byte frame on port 0, MAC acks every 4th cycle.
    exp_q.delete();
    model_on = 1'b1;
    port_en  = 2'b11;
    set_src(0, 1, 60, -1);
    set_src(1, 0, 1, -1);
    drive_src();
    expect_frame(0, 0, 60, 60);
    ack_div = 4;
    cyc = 0;
    tx_ack = 1'b0;
    do_reset();
    ack1_seen = 1'b0;
    drain("single_drain", 400);
    chk("single_frm_cnt0", {16'd0, frm_cnt0}, 32'd1);
    chk("single_frm_cnt1", {16'd0, frm_cnt1}, 32'd0);
    chk("single_ack1_never", {31'd0, ack1_seen}, 32'd0);

    // Contention: both ports hold sof from reset, two frames each.
    exp_q.delete();
    set_src(0, 2, 6, -1);
    set_src(1, 2, 7, -1);
    drive_src();
    expect_frame(0, 0, 6, 6);
    expect_frame(1, 0, 7, 7);
    expect_frame(0, 1, 6, 6);
    expect_frame(1, 1, 7, 7);
    ack_div = 2;
    do_reset();
    drain("contend_drain", 200);
    chk("contend_frm_cnt0", {16'd0, frm_cnt0}, 32'd2);
    chk("contend_frm_cnt1", {16'd0, frm_cnt1}, 32'd2);

    // Orphans while idle.
    model_on = 1'b0;
    port_en  = 2'b11;
    src_vld  = 2'b00;
    src_sof  = 2'b00;
    src_eof  = 2'b00;
    do_reset();
    src_vld = 2'b10;
    src_dat = 16'h5500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_mac);
      chk($sformatf("orphan_ack_%0d", i), {30'd0, src_ack}, 32'd2);
      chk($sformatf("orphan_txvld_%0d", i), {31'd0, tx_vld}, 32'd0);
      @(posedge clk_mac);
      #1;
    end
    src_vld = 2'b00;
    @(negedge clk_mac);
    chk("orphan_drop3", {24'd0, drop_cnt}, 32'd3);
    src_vld = 2'b11;
    repeat (150) @(posedge clk_mac);
    #1;
    src_vld = 2'b00;
    @(negedge clk_mac);
    chk("orphan_drop_sat", {24'd0, drop_cnt}, 32'd255);

    // Underrun: port 0 starves after 10 bytes, port 1 must follow.
    exp_q.delete();
    model_on = 1'b1;
    set_src(0, 1, 20, 10);
    set_src(1, 1, 5, -1);
    drive_src();
    expect_frame(0, 0, 10, 20);
    expect_frame(1, 0, 5, 5);
    ack_div = 1;
    tx_ack = 1'b1;
    do_reset();
    n_under = 0;
    drain("under_drain", 100);
    repeat (3) cycle();
    chk("under_pulses", n_under, 1);
    chk("under_frm_cnt0", {16'd0, frm_cnt0}, 32'd0);
    chk("under_frm_cnt1", {16'd0, frm_cnt1}, 32'd1);

    // Enable mask: only port 0 may be granted.
    exp_q.delete();
    model_on = 1'b0;
    set_src(0, 1, 4, -1);
    set_src(1, 1, 4, -1);
    port_en = 2'b01;
    model_on = 1'b1;
    drive_src();
    expect_frame(0, 0, 4, 4);
    do_reset();
    drain("en_drain", 50);
    repeat (10) cycle();
    chk("en_frm_cnt0", {16'd0, frm_cnt0}, 32'd1);
    chk("en_frm_cnt1", {16'd0, frm_cnt1}, 32'd0);

    // Reset mid-frame with a nonzero counter present.
    exp_q.delete();
    port_en = 2'b11;
    set_src(0, 1, 30, -1);
    set_src(1, 0, 1, -1);
    fcnt[0] = 1;
    drive_src();
    expect_frame(0, 1, 30, 30);
    n_under = 0;
    repeat (5) cycle();
    @(negedge clk_mac);
    chk("midrst_pre_vld", {31'd0, tx_vld}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("midrst_src_ack", {30'd0, src_ack}, 32'd0);
    chk("midrst_frm_cnt0", {16'd0, frm_cnt0}, 32'd0);
    chk("midrst_frm_cnt1", {16'd0, frm_cnt1}, 32'd0);
    chk("midrst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("midrst_underrun", {31'd0, underrun}, 32'd0);
    model_on = 1'b0;
    drive_src();
    exp_q.delete();
    repeat (2) @(posedge clk_mac);
    #1;
    rst = 1'b0;
    repeat (3) cycle();
    chk("midrst_no_underrun", n_under, 0);
    chk("midrst_frm_cnt0_after", {16'd0, frm_cnt0}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
